md_unit: RTL and testbench

//  Multi-cycle multiply/divide unit in the E stage; sole producer of the HI/LO values consumed by the E/M pipeline register.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit.sv | 143 ++++++++++++++
 tb/tb_md_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and op-class helpers.
package md_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    // True for ops that occupy the unit for a multi-cycle busy period.
    function automatic logic md_is_long_op(input logic [MD_OP_W-1:0] op);
        logic long_s;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: long_s = 1'b1;
            default:                            long_s = 1'b0;
        endcase
        return long_s;
    endfunction

    // True for divide ops (selects the divide latency).
    function automatic logic md_is_div_op(input logic [MD_OP_W-1:0] op);
        logic div_s;
        case (op)
            MD_DIV, MD_DIVU: div_s = 1'b1;
            default:         div_s = 1'b0;
        endcase
        return div_s;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage to multiply/divide unit connection: op launch and HI/LO/busy return.
interface md_unit_if;
    import md_pkg::*;

    logic               start;
    logic [MD_OP_W-1:0] md_op;
    logic [31:0]        A;
    logic [31:0]        B;
    logic               busy;
    logic [31:0]        HI;
    logic [31:0]        LO;

    // E stage side: launches ops, observes busy and HI/LO.
    modport master (
        output start, md_op, A, B,
        input  busy, HI, LO
    );

    // Unit side.
    modport slave (
        input  start, md_op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit. Results are computed in one go at launch,
// parked in pending registers and released to HI/LO after a fixed latency,
// so the pipeline sees realistic busy/stall timing.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  md
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_valid_r;

    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             res_valid_s;

    logic [63:0]      prod_s_s;
    logic [63:0]      prod_u_s;
    logic [31:0]      abs_a_s;
    logic [31:0]      abs_b_s;
    logic [31:0]      udivisor_s;
    logic [31:0]      sdivisor_s;
    logic [31:0]      uq_s;
    logic [31:0]      ur_s;
    logic [31:0]      sq_mag_s;
    logic [31:0]      sr_mag_s;

    // Compute the 64-bit result of the op presented this cycle.
    // Divisors are forced non-zero internally so the operators never see /0;
    // a zero divisor is reported through res_valid_s instead.
    always_comb begin
        prod_s_s    = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
        prod_u_s    = {32'd0, md.A} * {32'd0, md.B};
        abs_a_s     = md.A[31] ? (32'd0 - md.A) : md.A;
        abs_b_s     = md.B[31] ? (32'd0 - md.B) : md.B;
        udivisor_s  = (md.B == 32'd0) ? 32'd1 : md.B;
        sdivisor_s  = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
        uq_s        = md.A / udivisor_s;
        ur_s        = md.A % udivisor_s;
        sq_mag_s    = abs_a_s / sdivisor_s;
        sr_mag_s    = abs_a_s % sdivisor_s;
        res_hi_s    = 32'd0;
        res_lo_s    = 32'd0;
        res_valid_s = 1'b0;
        case (md.md_op)
            MD_MULT: begin
                res_hi_s    = prod_s_s[63:32];
                res_lo_s    = prod_s_s[31:0];
                res_valid_s = 1'b1;
            end
            MD_MULTU: begin
                res_hi_s    = prod_u_s[63:32];
                res_lo_s    = prod_u_s[31:0];
                res_valid_s = 1'b1;
            end
            MD_DIV: begin
                // Magnitude divide then fix signs: quotient negative when the
                // operand signs differ, remainder follows the dividend.
                // 0x80000000 / -1 falls out as 0x80000000 rem 0.
                res_lo_s    = (md.A[31] ^ md.B[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
                res_hi_s    = md.A[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
                res_valid_s = (md.B != 32'd0);
            end
            MD_DIVU: begin
                res_lo_s    = uq_s;
                res_hi_s    = ur_s;
                res_valid_s = (md.B != 32'd0);
            end
            default: begin
                res_hi_s    = 32'd0;
                res_lo_s    = 32'd0;
                res_valid_s = 1'b0;
            end
        endcase
    end

    // Sequence launch, latency countdown, completion and direct HI/LO moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r       <= 1'b0;
            cnt_r        <= '0;
            hi_r         <= 32'd0;
            lo_r         <= 32'd0;
            pend_hi_r    <= 32'd0;
            pend_lo_r    <= 32'd0;
            pend_valid_r <= 1'b0;
        end else if (busy_r) begin
            // Starts are ignored while busy; only the countdown advances.
            if (cnt_r == '0) begin
                busy_r <= 1'b0;
                if (pend_valid_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end else begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            end else begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end else if (md.start) begin
            if (md_is_long_op(md.md_op)) begin
                busy_r       <= 1'b1;
                cnt_r        <= md_is_div_op(md.md_op) ? DIV_LOAD : MULT_LOAD;
                pend_hi_r    <= res_hi_s;
                pend_lo_r    <= res_lo_s;
                pend_valid_r <= res_valid_s;
            end else begin
                case (md.md_op)
                    MD_MTHI: hi_r <= md.A;
                    MD_MTLO: lo_r <= md.A;
                    default: begin
                        hi_r <= hi_r;
                        lo_r <= lo_r;
                    end
                endcase
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign md.busy = busy_r;
    assign md.HI   = hi_r;
    assign md.LO   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, arithmetic corner cases,
// direct HI/LO moves, ignored starts and reset abort.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;

    md_unit_if md_if ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op for exactly one rising edge; returns at the negedge after it.
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        md_if.md_op = op;
        md_if.A     = a;
        md_if.B     = b;
        md_if.start = 1'b1;
        @(negedge clk);
        md_if.start = 1'b0;
    endtask

    // Count busy cycles (bounded) while checking HI/LO stay at their old values.
    task automatic wait_done(input string tag, input int n,
                             input logic [31:0] hi_old, input logic [31:0] lo_old);
        int  cyc;
        bit  held;
        cyc  = 0;
        held = 1'b1;
        while (md_if.busy && cyc < 100) begin
            if (md_if.HI !== hi_old || md_if.LO !== lo_old) held = 1'b0;
            cyc++;
            @(negedge clk);
        end
        check({tag, " busy_len"}, 32'(cyc), 32'(n));
        check({tag, " held"}, {31'd0, held}, 32'd1);
    endtask

    task automatic long_op(input string tag, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input int n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi_old;
        logic [31:0] lo_old;
        hi_old = md_if.HI;
        lo_old = md_if.LO;
        launch(op, a, b);
        wait_done(tag, n, hi_old, lo_old);
        check({tag, " HI"}, md_if.HI, exp_hi);
        check({tag, " LO"}, md_if.LO, exp_lo);
        check({tag, " busy_end"}, {31'd0, md_if.busy}, 32'd0);
    endtask

    initial begin
        chk_cnt     = 0;
        pass_cnt    = 0;
        reset       = 1'b1;
        md_if.start = 1'b0;
        md_if.md_op = MD_MULT;
        md_if.A     = 32'd0;
        md_if.B     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst busy", {31'd0, md_if.busy}, 32'd0);
        check("rst HI", md_if.HI, 32'd0);
        check("rst LO", md_if.LO, 32'd0);

        // Preset so that "held" during the multiply is meaningful.
        launch(MD_MTHI, 32'h11, 32'd0);
        launch(MD_MTLO, 32'h22, 32'd0);
        check("preset HI", md_if.HI, 32'h11);
        check("preset LO", md_if.LO, 32'h22);

        long_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        long_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        long_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        long_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);

        launch(MD_MTHI, 32'h11, 32'd0);
        launch(MD_MTLO, 32'h22, 32'd0);
        long_op("divu0", MD_DIVU, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        long_op("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        long_op("divovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

        // Back-to-back mthi / mtlo.
        @(negedge clk);
        md_if.md_op = MD_MTHI;
        md_if.A     = 32'hDEAD;
        md_if.start = 1'b1;
        @(negedge clk);
        check("mthi HI", md_if.HI, 32'hDEAD);
        check("mthi busy", {31'd0, md_if.busy}, 32'd0);
        md_if.md_op = MD_MTLO;
        md_if.A     = 32'hBEEF;
        @(negedge clk);
        md_if.start = 1'b0;
        check("mtlo LO", md_if.LO, 32'hBEEF);
        check("mtlo HI", md_if.HI, 32'hDEAD);
        check("mtlo busy", {31'd0, md_if.busy}, 32'd0);

        // Invalid op code: no state change.
        launch(3'd7, 32'h1234, 32'h5678);
        check("inv busy", {31'd0, md_if.busy}, 32'd0);
        check("inv HI", md_if.HI, 32'hDEAD);
        check("inv LO", md_if.LO, 32'hBEEF);

        // Second start in the middle of a divide is ignored.
        launch(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        md_if.md_op = MD_MTLO;
        md_if.A     = 32'h5555;
        md_if.start = 1'b1;
        @(negedge clk);
        md_if.start = 1'b0;
        check("midstart busy", {31'd0, md_if.busy}, 32'd1);
        check("midstart LO", md_if.LO, 32'hBEEF);
        wait_done("midstart", 6, 32'hDEAD, 32'hBEEF);
        check("midstart HI", md_if.HI, 32'd2);
        check("midstart LO end", md_if.LO, 32'd14);

        // Reset in the third busy cycle of a divide aborts it.
        launch(MD_DIV, 32'd50, 32'd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, md_if.busy}, 32'd0);
        check("abort HI", md_if.HI, 32'd0);
        check("abort LO", md_if.LO, 32'd0);
        long_op("postrst", MD_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd42);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
